// File: rtl/muldiv_seq_ctl_if.sv
// Handshake bundle between the pipeline control and the HI/LO mul/div sequencer.
// master = pipeline side, slave = sequencer.
interface muldiv_seq_ctl_if;
  logic [31:0] instrD;
  logic [31:0] instrE;
  logic        b_zero;
  logic        cancel;
  logic        md_start;
  logic [1:0]  md_op;
  logic        busy;
  logic        hilo_we;
  logic        stall_md;

  modport master (
    output instrD, instrE, b_zero, cancel,
    input  md_start, md_op, busy, hilo_we, stall_md
  );

  modport slave (
    input  instrD, instrE, b_zero, cancel,
    output md_start, md_op, busy, hilo_we, stall_md
  );
endinterface

// File: rtl/muldiv_seq_ctl.sv
// Launch/latency/stall sequencer for the multi-cycle HI/LO multiply/divide unit.
// Optional MDU_DIVZERO_FAST_EN: divide by zero skips the latency and leaves HI/LO untouched.
module muldiv_seq_ctl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  muldiv_seq_ctl_if.slave   md
);

  localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW    = ($clog2(MAX_N) > 4) ? $clog2(MAX_N) : 4;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [1:0]    md_op_q;
  logic          dz;
  logic          is_md_e;
  logic          is_hilo_d;
  logic          launch_dz;
  logic          md_start;
  logic          hilo_we;
  logic          stall_md;

  always_comb begin
    is_md_e   = (md.instrE[31:26] == 6'h00) && (md.instrE[5:2] == 4'b0110);
    is_hilo_d = (md.instrD[31:26] == 6'h00) &&
                ((md.instrD[5:2] == 4'b0110) || (md.instrD[5:2] == 4'b0100));
  end

`ifdef MDU_DIVZERO_FAST_EN
  assign launch_dz = is_md_e & md.instrE[1] & md.b_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        dz <= 1'b0;
    else if (md_start) dz <= launch_dz;
  end

  logic unused_bits;
  assign unused_bits = ^{md.instrD[25:6], md.instrD[1:0], md.instrE[25:6]};
`else
  assign launch_dz = 1'b0;
  assign dz        = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{md.instrD[25:6], md.instrD[1:0], md.instrE[25:6], md.b_zero};
`endif

  always_comb begin
    state_nx = state;
    md_start = 1'b0;
    hilo_we  = 1'b0;
    case (state)
      IDLE: begin
        md_start = is_md_e & ~md.cancel;
        if (md_start) state_nx = launch_dz ? DONE : BUSY;
      end
      BUSY: begin
        if (cnt == '0) state_nx = DONE;
      end
      DONE: begin
        hilo_we  = ~md.cancel & ~dz;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (md.cancel) state_nx = IDLE;
  end

  // DONE is excluded: HI/LO is written at the DONE edge, before a released reader reaches E.
  always_comb begin
    stall_md = ((state == BUSY) | md_start) & is_hilo_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      md_op_q <= '0;
    end else if (md_start) begin
      cnt     <= md.instrE[1] ? DIV_LOAD : MULT_LOAD;
      md_op_q <= md.instrE[1:0];
    end else if ((state == BUSY) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign md.md_start = md_start;
  assign md.md_op    = md_op_q;
  assign md.busy     = (state != IDLE);
  assign md.hilo_we  = hilo_we;
  assign md.stall_md = stall_md;

endmodule

// File: tb/tb_muldiv_seq_ctl.sv
// Directed bench for muldiv_seq_ctl with default MULT_CYCLES=5 / DIV_CYCLES=10.
// Outputs are sampled on the falling edge; inputs change 1 ns after the rising edge.
module tb_muldiv_seq_ctl;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] MULT = 32'h0109_5018;
  localparam logic [31:0] DIV  = 32'h0109_501A;
  localparam logic [31:0] DIVU = 32'h0109_501B;
  localparam logic [31:0] MFLO = 32'h0000_1012;
  localparam logic [31:0] MTHI = 32'h0100_0011;
  localparam logic [31:0] ADD  = 32'h0109_5020;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  logic [3:0] obs, exp;

  muldiv_seq_ctl_if md_if ();

  muldiv_seq_ctl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (md_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic quiet;
    md_if.instrD = NOP;
    md_if.instrE = NOP;
    md_if.b_zero = 1'b0;
    md_if.cancel = 1'b0;
  endtask

  task automatic test_reset;
    quiet();
    rst_n = 1'b0;
    @(negedge clk);
    obs = {md_if.md_start, md_if.busy, md_if.hilo_we, md_if.stall_md};
    vectors++;
    if (obs !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_outputs: {start,busy,we,stall} got %b want 0000", obs);
    end
    vectors++;
    if (md_if.md_op !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_md_op: got %b want 00", md_if.md_op);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mult;
    for (int c = 0; c <= 8; c++) begin
      quiet();
      if (c == 0) md_if.instrE = MULT;
      @(negedge clk);
      obs = {md_if.md_start, md_if.busy, md_if.hilo_we, md_if.stall_md};
      exp = {c == 0, (c >= 1) && (c <= 6), c == 6, 1'b0};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL mult cyc %0d: {start,busy,we,stall} got %b want %b", c, obs, exp);
      end
      if (c == 1) begin
        vectors++;
        if (md_if.md_op !== 2'b00) begin
          miscompares++;
          $display("FAIL mult_md_op: got %b want 00", md_if.md_op);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_divu_stall;
    for (int c = 0; c <= 12; c++) begin
      quiet();
      md_if.instrD = MFLO;
      if (c == 0) md_if.instrE = DIVU;
      @(negedge clk);
      obs = {md_if.md_start, md_if.busy, md_if.hilo_we, md_if.stall_md};
      exp = {c == 0, (c >= 1) && (c <= 11), c == 11, c <= 10};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL divu_stall cyc %0d: {start,busy,we,stall} got %b want %b", c, obs, exp);
      end
      if (c == 1) begin
        vectors++;
        if (md_if.md_op !== 2'b11) begin
          miscompares++;
          $display("FAIL divu_md_op: got %b want 11", md_if.md_op);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_cancel;
    for (int c = 0; c <= 14; c++) begin
      quiet();
      if (c == 0) md_if.instrE = DIV;
      if (c == 4) md_if.cancel = 1'b1;
      @(negedge clk);
      obs = {md_if.md_start, md_if.busy, md_if.hilo_we, md_if.stall_md};
      exp = {c == 0, (c >= 1) && (c <= 4), 1'b0, 1'b0};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL cancel_busy cyc %0d: {start,busy,we,stall} got %b want %b", c, obs, exp);
      end
      @(posedge clk); #1;
    end
    // cancel coinciding with a launch candidate
    for (int c = 0; c <= 2; c++) begin
      quiet();
      if (c == 0) begin
        md_if.instrE = MULT;
        md_if.cancel = 1'b1;
        md_if.instrD = MFLO;
      end
      @(negedge clk);
      obs = {md_if.md_start, md_if.busy, md_if.hilo_we, md_if.stall_md};
      vectors++;
      if (obs !== 4'b0000) begin
        miscompares++;
        $display("FAIL cancel_launch cyc %0d: {start,busy,we,stall} got %b want 0000", c, obs);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset;
    for (int c = 0; c <= 3; c++) begin
      quiet();
      if (c == 0) md_if.instrE = MULT;
      @(negedge clk);
      obs = {md_if.md_start, md_if.busy, md_if.hilo_we, md_if.stall_md};
      exp = {c == 0, c >= 1, 1'b0, 1'b0};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL areset_pre cyc %0d: {start,busy,we,stall} got %b want %b", c, obs, exp);
      end
      if (c == 3) begin
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (md_if.busy !== 1'b0 || md_if.hilo_we !== 1'b0) begin
          miscompares++;
          $display("FAIL areset_immediate: busy %b we %b want 0 0", md_if.busy, md_if.hilo_we);
        end
        #1 rst_n = 1'b1;
      end
      @(posedge clk); #1;
    end
    for (int c = 4; c <= 8; c++) begin
      quiet();
      @(negedge clk);
      obs = {md_if.md_start, md_if.busy, md_if.hilo_we, md_if.stall_md};
      vectors++;
      if (obs !== 4'b0000) begin
        miscompares++;
        $display("FAIL areset_post cyc %0d: {start,busy,we,stall} got %b want 0000", c, obs);
      end
      @(posedge clk); #1;
    end
    test_mult();
  endtask

  task automatic test_non_hilo;
    for (int c = 0; c <= 7; c++) begin
      quiet();
      md_if.instrD = ADD;
      if (c == 0) md_if.instrE = MULT;
      @(negedge clk);
      vectors++;
      if (md_if.stall_md !== 1'b0) begin
        miscompares++;
        $display("FAIL add_in_d cyc %0d: stall got %b want 0", c, md_if.stall_md);
      end
      @(posedge clk); #1;
    end
    // mthi in D during the last BUSY cycle, then during DONE
    for (int c = 0; c <= 7; c++) begin
      quiet();
      if (c == 5 || c == 6) md_if.instrD = MTHI;
      if (c == 0) md_if.instrE = MULT;
      @(negedge clk);
      obs = {md_if.md_start, md_if.busy, md_if.hilo_we, md_if.stall_md};
      exp = {c == 0, (c >= 1) && (c <= 6), c == 6, c == 5};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL mthi_done cyc %0d: {start,busy,we,stall} got %b want %b", c, obs, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_divzero;
    for (int c = 0; c <= 12; c++) begin
      quiet();
      if (c == 0) begin
        md_if.instrE = DIV;
        md_if.b_zero = 1'b1;
      end
      @(negedge clk);
      obs = {md_if.md_start, md_if.busy, md_if.hilo_we, md_if.stall_md};
`ifdef MDU_DIVZERO_FAST_EN
      exp = {c == 0, c == 1, 1'b0, 1'b0};
`else
      exp = {c == 0, (c >= 1) && (c <= 11), c == 11, 1'b0};
`endif
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL divzero cyc %0d: {start,busy,we,stall} got %b want %b", c, obs, exp);
      end
      @(posedge clk); #1;
    end
    test_mult();
  endtask

  task automatic test_back_to_back;
    for (int c = 0; c <= 19; c++) begin
      quiet();
      if (c <= 6) md_if.instrD = DIVU;
      if (c == 0) md_if.instrE = MULT;
      if (c == 7) md_if.instrE = DIVU;
      @(negedge clk);
      obs = {md_if.md_start, md_if.busy, md_if.hilo_we, md_if.stall_md};
      exp = {(c == 0) || (c == 7),
             ((c >= 1) && (c <= 6)) || ((c >= 8) && (c <= 18)),
             (c == 6) || (c == 18),
             c <= 5};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL back_to_back cyc %0d: {start,busy,we,stall} got %b want %b", c, obs, exp);
      end
      if (c == 8) begin
        vectors++;
        if (md_if.md_op !== 2'b11) begin
          miscompares++;
          $display("FAIL back_to_back_md_op: got %b want 11", md_if.md_op);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    quiet();
    test_reset();
    test_mult();
    test_divu_stall();
    test_cancel();
    test_async_reset();
    test_non_hilo();
    test_divzero();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
